// File: rtl/rcu_pkg.sv
// -----------------------------------------------------------------------------
// rcu_pkg
// Shared definitions for the reset/clock sequencer: the sequencer state
// encoding, reset-cause codes, the per-state output decode and a small
// constant helper used for counter sizing.
// -----------------------------------------------------------------------------
package rcu_pkg;

   typedef enum logic [2:0] {
      HOLD   = 3'd0,
      PRECLK = 3'd1,
      RUN    = 3'd2,
      DRAIN  = 3'd3,
      SLEEP  = 3'd4
   } rcu_state_e;

   localparam logic [1:0] CAUSE_POR = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;
   localparam logic [1:0] CAUSE_WDT = 2'b11;

   typedef struct packed {
      logic rsten;
      logic clken;
      logic sleep_ack;
   } rcu_out_t;

   // Output levels presented to the RCU while sitting in a given state.
   function automatic rcu_out_t decode_out(input rcu_state_e s);
      rcu_out_t o;
      case (s)
         HOLD:    o = '{rsten: 1'b0, clken: 1'b0, sleep_ack: 1'b0};
         PRECLK:  o = '{rsten: 1'b0, clken: 1'b1, sleep_ack: 1'b0};
         RUN:     o = '{rsten: 1'b1, clken: 1'b1, sleep_ack: 1'b0};
         DRAIN:   o = '{rsten: 1'b1, clken: 1'b1, sleep_ack: 1'b0};
         SLEEP:   o = '{rsten: 1'b1, clken: 1'b0, sleep_ack: 1'b1};
         default: o = '{rsten: 1'b0, clken: 1'b0, sleep_ack: 1'b0};
      endcase
      return o;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rcu_seq.sv
// -----------------------------------------------------------------------------
// rcu_seq
// Reset/clock sequencer feeding the RCU. Brings the system up in order
// (clock gated with reset held, then clock running with reset held, then
// reset released), handles handshaked entry to / exit from clock-gated
// sleep, services software reset requests and records the last reset cause.
//
// Parameters:
//   RST_HOLD_CYCLES  cycles in HOLD (clock gated, reset asserted), >= 1
//   CLK_PRE_CYCLES   cycles in PRECLK (clock running, reset asserted), >= 1
//   WDT_CYCLES       drain watchdog timeout, only used with RCU_SEQ_WDT_EN
//
// Ports:
//   EXTCLK     in   free-running clock, all state changes on its rising edge
//   EXTRST     in   asynchronous active-high reset
//   swrst_req  in   software reset request (level or pulse)
//   sleep_req  in   sleep request (level)
//   core_idle  in   core has no outstanding activity
//   wake       in   wake event
//   rsten      out  reset enable to RCU (0 = hold system in reset)
//   clken      out  clock enable to RCU (0 = gate system clock)
//   sleep_ack  out  high while in SLEEP
//   rst_cause  out  last reset cause: 01 POR, 10 SW, 11 WDT
//
// Build option:
//   RCU_SEQ_WDT_EN  when defined, DRAIN is bounded by a watchdog that forces
//                   a reset (cause 11) if the core never reports idle.
// -----------------------------------------------------------------------------
module rcu_seq
   import rcu_pkg::*;
#(
   parameter int RST_HOLD_CYCLES = 16,
   parameter int CLK_PRE_CYCLES  = 4,
   parameter int WDT_CYCLES      = 1024
) (
   input  logic       EXTCLK,
   input  logic       EXTRST,
   input  logic       swrst_req,
   input  logic       sleep_req,
   input  logic       core_idle,
   input  logic       wake,
   output logic       rsten,
   output logic       clken,
   output logic       sleep_ack,
   output logic [1:0] rst_cause
);

`ifdef RCU_SEQ_WDT_EN
   localparam int WDT_SPAN = WDT_CYCLES;
`else
   // Watchdog not built: the timeout contributes nothing to counter sizing.
   localparam int WDT_SPAN = (WDT_CYCLES >= 1) ? 1 : 1;
`endif

   localparam int CNT_MAX = max2(max2(RST_HOLD_CYCLES, CLK_PRE_CYCLES), WDT_SPAN);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CLK_PRE_CYCLES - 1);
`ifdef RCU_SEQ_WDT_EN
   localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);
`endif

   rcu_state_e       state;
   rcu_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [1:0]       cause_nxt;
   logic             count_en;
   logic             restart;
   rcu_out_t         out_nxt;

   // Next-state, counter and cause selection; swrst_req has top priority,
   // then the watchdog, then the ordinary transitions.
   always_comb begin
      state_nxt = state;
      cause_nxt = rst_cause;
      count_en  = 1'b0;
      restart   = 1'b0;
      case (state)
         HOLD: begin
            // A request during HOLD is remembered but the hold always completes.
            if (swrst_req) begin
               cause_nxt = CAUSE_SW;
            end else begin
               cause_nxt = rst_cause;
            end
            if (cnt == HOLD_LAST) begin
               state_nxt = PRECLK;
            end else begin
               count_en = 1'b1;
            end
         end
         PRECLK: begin
            if (swrst_req) begin
               // Re-requests restart the pre-release window.
               restart   = 1'b1;
               cause_nxt = CAUSE_SW;
            end else if (cnt == PRE_LAST) begin
               state_nxt = RUN;
            end else begin
               count_en = 1'b1;
            end
         end
         RUN: begin
            if (swrst_req) begin
               state_nxt = PRECLK;
               cause_nxt = CAUSE_SW;
            end else if (sleep_req) begin
               state_nxt = DRAIN;
            end else begin
               state_nxt = RUN;
            end
         end
         DRAIN: begin
            if (swrst_req) begin
               state_nxt = PRECLK;
               cause_nxt = CAUSE_SW;
`ifdef RCU_SEQ_WDT_EN
            end else if ((cnt == WDT_LAST) && !core_idle) begin
               // Idle on the timeout cycle still wins and enters SLEEP below.
               state_nxt = PRECLK;
               cause_nxt = CAUSE_WDT;
`endif
            end else if (!sleep_req) begin
               state_nxt = RUN;
            end else if (core_idle) begin
               state_nxt = SLEEP;
            end else begin
`ifdef RCU_SEQ_WDT_EN
               count_en = 1'b1;
`else
               count_en = 1'b0;
`endif
            end
         end
         SLEEP: begin
            if (swrst_req) begin
               state_nxt = PRECLK;
               cause_nxt = CAUSE_SW;
            end else if (wake || !sleep_req) begin
               state_nxt = RUN;
            end else begin
               state_nxt = SLEEP;
            end
         end
         default: begin
            state_nxt = HOLD;
            cause_nxt = CAUSE_POR;
         end
      endcase

      // The shared counter clears on every state change or PRECLK restart.
      if (restart || (state_nxt != state)) begin
         cnt_nxt = '0;
      end else if (count_en) begin
         cnt_nxt = cnt + CNT_W'(1);
      end else begin
         cnt_nxt = cnt;
      end

      out_nxt = decode_out(state_nxt);
   end

   // State, counter, cause and registered output decode.
   always_ff @(posedge EXTCLK or posedge EXTRST) begin
      if (EXTRST) begin
         state     <= HOLD;
         cnt       <= '0;
         rsten     <= 1'b0;
         clken     <= 1'b0;
         sleep_ack <= 1'b0;
         rst_cause <= CAUSE_POR;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rsten     <= out_nxt.rsten;
         clken     <= out_nxt.clken;
         sleep_ack <= out_nxt.sleep_ack;
         rst_cause <= cause_nxt;
      end
   end

endmodule

// File: tb/tb_rcu_seq.sv
// -----------------------------------------------------------------------------
// tb_rcu_seq
// Directed self-checking bench for rcu_seq with default hold/pre-release
// lengths and an 8-cycle watchdog (the watchdog scenario follows the
// RCU_SEQ_WDT_EN build option).
// Observed vector per check: {rsten, clken, sleep_ack, rst_cause}.
// -----------------------------------------------------------------------------
module tb_rcu_seq;

   logic       clk;
   logic       rst;
   logic       swrst_req;
   logic       sleep_req;
   logic       core_idle;
   logic       wake;
   logic       rsten;
   logic       clken;
   logic       sleep_ack;
   logic [1:0] rst_cause;

   int n_cmp;
   int n_bad;

   rcu_seq #(
      .RST_HOLD_CYCLES(16),
      .CLK_PRE_CYCLES (4),
      .WDT_CYCLES     (8)
   ) dut (
      .EXTCLK   (clk),
      .EXTRST   (rst),
      .swrst_req(swrst_req),
      .sleep_req(sleep_req),
      .core_idle(core_idle),
      .wake     (wake),
      .rsten    (rsten),
      .clken    (clken),
      .sleep_ack(sleep_ack),
      .rst_cause(rst_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      rst = 1'b1; swrst_req = 1'b0; sleep_req = 1'b0; core_idle = 1'b0; wake = 1'b0;
      tick(); tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b00001) begin
         n_bad++;
         $display("FAIL reset_values: got %b want %b", obs, 5'b00001);
      end
   endtask

   task automatic test_power_on();
      logic [4:0] obs;
      logic [4:0] exp;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         tick();
         exp = {(k >= 20) ? 1'b1 : 1'b0, (k >= 16) ? 1'b1 : 1'b0, 1'b0, 2'b01};
         obs = {rsten, clken, sleep_ack, rst_cause};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL power_on edge %0d: got %b want %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_swrst_pulse();
      logic [4:0] obs;
      swrst_req = 1'b1;
      tick();
      swrst_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         obs = {rsten, clken, sleep_ack, rst_cause};
         n_cmp++;
         if (obs !== 5'b01010) begin
            n_bad++;
            $display("FAIL swrst_pulse cycle %0d: got %b want %b", i, obs, 5'b01010);
         end
         tick();
      end
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b11010) begin
         n_bad++;
         $display("FAIL swrst_pulse release: got %b want %b", obs, 5'b11010);
      end
   endtask

   task automatic test_swrst_held();
      logic [4:0] obs;
      logic [4:0] exp;
      // Request held for 3 edges: release only 4 edges after the last one.
      for (int k = 1; k <= 7; k++) begin
         swrst_req = (k <= 3) ? 1'b1 : 1'b0;
         tick();
         exp = {(k >= 7) ? 1'b1 : 1'b0, 1'b1, 1'b0, 2'b10};
         obs = {rsten, clken, sleep_ack, rst_cause};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL swrst_held edge %0d: got %b want %b", k, obs, exp);
         end
      end
      swrst_req = 1'b0;
   endtask

   task automatic test_sleep_cycle();
      logic [4:0] obs;
      logic       drop;
      sleep_req = 1'b1;
      drop = 1'b0;
      // Seven DRAIN cycles with the core busy: clock and reset must stay on.
      for (int i = 0; i < 7; i++) begin
         tick();
         if ({rsten, clken, sleep_ack} !== 3'b110) drop = 1'b1;
      end
      n_cmp++;
      if (drop !== 1'b0) begin
         n_bad++;
         $display("FAIL sleep_drain_hold: got drop=%b want %b", drop, 1'b0);
      end
      core_idle = 1'b1;
      tick();
      core_idle = 1'b0;
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b10110) begin
         n_bad++;
         $display("FAIL sleep_entry: got %b want %b", obs, 5'b10110);
      end
      tick(); tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b10110) begin
         n_bad++;
         $display("FAIL sleep_stay: got %b want %b", obs, 5'b10110);
      end
      wake = 1'b1;
      tick();
      wake = 1'b0;
      sleep_req = 1'b0;
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b11010) begin
         n_bad++;
         $display("FAIL sleep_wake: got %b want %b", obs, 5'b11010);
      end
      tick();
   endtask

   task automatic test_drain_abort();
      logic [4:0] obs;
      sleep_req = 1'b1;
      tick();
      sleep_req = 1'b0;
      tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b11010) begin
         n_bad++;
         $display("FAIL drain_abort: got %b want %b", obs, 5'b11010);
      end
      // Back in RUN: idle plus request only reaches DRAIN on this edge.
      sleep_req = 1'b1;
      core_idle = 1'b1;
      tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b11010) begin
         n_bad++;
         $display("FAIL drain_abort_run: got %b want %b", obs, 5'b11010);
      end
      tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b10110) begin
         n_bad++;
         $display("FAIL drain_abort_sleep: got %b want %b", obs, 5'b10110);
      end
      core_idle = 1'b0;
      sleep_req = 1'b0;
      tick();
   endtask

   task automatic test_watchdog();
      logic [4:0] obs;
      logic       bad;
      sleep_req = 1'b1;
      core_idle = 1'b0;
      bad = 1'b0;
`ifdef RCU_SEQ_WDT_EN
      for (int i = 0; i < 8; i++) begin
         tick();
         if ({rsten, clken, sleep_ack} !== 3'b110) bad = 1'b1;
      end
      n_cmp++;
      if (bad !== 1'b0) begin
         n_bad++;
         $display("FAIL wdt_drain: got early=%b want %b", bad, 1'b0);
      end
      tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b01011) begin
         n_bad++;
         $display("FAIL wdt_fire: got %b want %b", obs, 5'b01011);
      end
      sleep_req = 1'b0;
      tick(); tick(); tick(); tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b11011) begin
         n_bad++;
         $display("FAIL wdt_release: got %b want %b", obs, 5'b11011);
      end
`else
      for (int i = 0; i < 1000; i++) begin
         tick();
         if ({rsten, clken, sleep_ack, rst_cause} !== 5'b11010) bad = 1'b1;
      end
      n_cmp++;
      if (bad !== 1'b0) begin
         n_bad++;
         $display("FAIL nowdt_drain: got left=%b want %b", bad, 1'b0);
      end
      // Still in DRAIN after 1000 cycles: idle now enters SLEEP.
      core_idle = 1'b1;
      tick();
      core_idle = 1'b0;
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b10110) begin
         n_bad++;
         $display("FAIL nowdt_sleep: got %b want %b", obs, 5'b10110);
      end
      sleep_req = 1'b0;
      tick();
`endif
   endtask

   task automatic test_async_reset();
      logic [4:0] obs;
      sleep_req = 1'b1;
      tick();
      core_idle = 1'b1;
      tick();
      core_idle = 1'b0;
      obs = {rsten, clken, sleep_ack};
      n_cmp++;
      if (obs[2:0] !== 3'b101) begin
         n_bad++;
         $display("FAIL async_pre_sleep: got %b want %b", obs[2:0], 3'b101);
      end
      // Assert mid high phase; check before any further clock edge.
      #2;
      rst = 1'b1;
      #1;
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b00001) begin
         n_bad++;
         $display("FAIL async_reset: got %b want %b", obs, 5'b00001);
      end
      sleep_req = 1'b0;
   endtask

   task automatic test_sleep_swrst_wake();
      logic [4:0] obs;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 21; k++) tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b11001) begin
         n_bad++;
         $display("FAIL rerun_por: got %b want %b", obs, 5'b11001);
      end
      sleep_req = 1'b1;
      core_idle = 1'b1;
      tick(); tick();
      core_idle = 1'b0;
      swrst_req = 1'b1;
      wake = 1'b1;
      tick();
      swrst_req = 1'b0;
      wake = 1'b0;
      sleep_req = 1'b0;
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b01010) begin
         n_bad++;
         $display("FAIL sleep_swrst_wake: got %b want %b", obs, 5'b01010);
      end
      tick(); tick(); tick(); tick();
      obs = {rsten, clken, sleep_ack, rst_cause};
      n_cmp++;
      if (obs !== 5'b11010) begin
         n_bad++;
         $display("FAIL sleep_swrst_release: got %b want %b", obs, 5'b11010);
      end
   endtask

   task automatic test_hold_swrst();
      logic [4:0] obs;
      logic [4:0] exp;
      rst = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         swrst_req = (k == 5) ? 1'b1 : 1'b0;
         tick();
         exp = {(k >= 20) ? 1'b1 : 1'b0, (k >= 16) ? 1'b1 : 1'b0, 1'b0,
                (k >= 5) ? 2'b10 : 2'b01};
         obs = {rsten, clken, sleep_ack, rst_cause};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL hold_swrst edge %0d: got %b want %b", k, obs, exp);
         end
      end
      swrst_req = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_power_on();
      test_swrst_pulse();
      test_swrst_held();
      test_sleep_cycle();
      test_drain_abort();
      test_watchdog();
      test_async_reset();
      test_sleep_swrst_wake();
      test_hold_swrst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rcu_seq.md
# rcu_seq

Reset/clock sequencer sitting directly upstream of the reset and clock unit: generates its `rsten` and `clken` controls from power-on, software-reset, sleep and wake events. It guarantees ordered bring-up:
- clock gated off while reset is stretched;
- clock enabled with reset still asserted for a fixed number of cycles;
- then reset released.

It also handles handshaked entry to and exit from clock-gated sleep, and records the cause of the last reset.

## Interface
- `RST_HOLD_CYCLES`, 16, cycles with clock gated and reset asserted after power-on (≥1)
- `CLK_PRE_CYCLES`, 4, cycles with clock running and reset asserted before release (≥1)
- `WDT_CYCLES`, 1024, drain watchdog timeout in cycles (≥1; used only with watchdog compiled in)

Ports:
- `EXTCLK`  in  1  external free-running clock; all state changes on its rising edge
- `EXTRST`  in  1  asynchronous, active-high reset
- `swrst_req`  in  1  software reset request, sampled each cycle (level or pulse)
- `sleep_req`  in  1  sleep request, level
- `core_idle`  in  1  core reports no outstanding activity
- `wake`  in  1  wake event, sampled each cycle
- `rsten`  out  1  reset enable to RCU (0 = hold system in reset)
- `clken`  out  1  clock enable to RCU (0 = gate system clock)
- `sleep_ack`  out  1  high while in SLEEP
- `rst_cause`  out  2  last reset cause: 01 POR, 10 SW, 11 WDT (00 unused)

## Operation
- **States:** HOLD, PRECLK, RUN, DRAIN, SLEEP. One shared cycle counter `cnt`, width `$clog2` of the largest parameter in use, cleared on every state change.
- **Reset values** (async, on `EXTRST`=1): state=HOLD, cnt=0, rsten=0, clken=0, sleep_ack=0, rst_cause=01.
- **HOLD:** rsten=0, clken=0. Advance to PRECLK when cnt==`RST_HOLD_CYCLES`-1.
- **PRECLK:** rsten=0, clken=1. Advance to RUN when cnt==`CLK_PRE_CYCLES`-1.
- **RUN:** rsten=1, clken=1.
  - `swrst_req` → PRECLK, rst_cause=10.
  - else `sleep_req` → DRAIN.
- **DRAIN:** rsten=1, clken=1.
  - `swrst_req` → PRECLK (cause 10).
  - else `!sleep_req` → RUN.
  - else `core_idle` → SLEEP.
- **SLEEP:** rsten=1, clken=0, sleep_ack=1.
  - `swrst_req` → PRECLK (cause 10).
  - else `wake` or `!sleep_req` → RUN.
- **Priority** in every state: `swrst_req` first, then watchdog, then the remaining transitions.
- A `swrst_req` held high keeps re-entering PRECLK. Release of `rsten` requires `swrst_req` to be low for `CLK_PRE_CYCLES` consecutive cycles, because the counter restarts on each request.
- `swrst_req` in HOLD or PRECLK restarts PRECLK counting, except in HOLD, which always completes its hold count first; rst_cause is updated to 10.
- All outputs are registered decodes of the state register. No combinational path from inputs to outputs.

## Timing
- **Power-on:** `clken` rises after the `RST_HOLD_CYCLES`-th rising edge following `EXTRST` deassertion. `rsten` rises `CLK_PRE_CYCLES` edges later (defaults: edges 16 and 20).
- **Input-to-state latency:** input sampled high at edge N gives the new state, and the outputs, after edge N.
- **Sleep entry:** `core_idle` sampled in DRAIN at edge N gives `clken`=0 and `sleep_ack`=1 after edge N.
- **Wake:** `wake` at edge N gives `clken`=1 and `sleep_ack`=0 after edge N. `rsten` stays 1 throughout.
- **Software reset:** `swrst_req` at edge N gives `rsten`=0 after edge N and `rsten`=1 after edge N+`CLK_PRE_CYCLES` if not re-requested. `clken` stays 1.
- **Clocking in SLEEP:** this block stays clocked by `EXTCLK` during SLEEP; glitch-free gating is the RCU's job.
- **Asynchronous reset mid-operation:** `EXTRST` in any state forces reset values immediately, regardless of the clock.

## Configuration
- Macro: `RCU_SEQ_WDT_EN`.
- **Defined:**
  - In DRAIN, cnt counts cycles.
  - If cnt==`WDT_CYCLES`-1 and `core_idle`=0 and no `swrst_req`: → PRECLK, rsten=0, rst_cause=11.
  - `core_idle` on the same cycle wins (→ SLEEP).
- **Not defined:** DRAIN waits indefinitely; rst_cause never takes 11; `WDT_CYCLES` is ignored.

## Structure
- Shared package `rcu_pkg`: state enum (HOLD, PRECLK, RUN, DRAIN, SLEEP), cause constants (CAUSE_POR=2'b01, CAUSE_SW=2'b10, CAUSE_WDT=2'b11).
- Single module. The counter is inline; no sub-module is natural at this size.

## Test plan
- Deassert `EXTRST`, defaults → `clken` 0→1 after edge 16, `rsten` 0→1 after edge 20, rst_cause=01.
- RUN, 1-cycle `swrst_req` → `rsten`=0 for exactly 4 cycles, `clken` stays 1, rst_cause=10.
- RUN, `sleep_req`=1, `core_idle` rises 7 cycles later → DRAIN 7 cycles, then `clken`=0, `sleep_ack`=1. Then `wake` pulse → `clken`=1, `sleep_ack`=0, `rsten` never drops.
- DRAIN, `sleep_req` drops before `core_idle` → back to RUN, `clken` never drops. Also `swrst_req` and `wake` together in SLEEP → PRECLK, cause 10.
- With `RCU_SEQ_WDT_EN`, `WDT_CYCLES`=8, `core_idle`=0 → after 8 DRAIN cycles `rsten`=0, rst_cause=11. Without the macro → stays in DRAIN for 1000 cycles.
- Assert `EXTRST` mid-SLEEP → `rsten`=0, `clken`=0, `sleep_ack`=0, rst_cause=01 immediately, without a clock edge.
